// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// ImmSrc codes match the Extend unit: 000 I, 001 S, 010 B, 011 J, 100 U.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALLINK, LUI, AUIPC
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_branch_resolve.sv
// Combinational branch condition: funct3 plus ALU compare flags -> taken.
module branch_resolve (
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       signedLess,
  input  logic       unsignedLess,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = signedLess;
      3'b101:  taken = ~signedLess;
      3'b110:  taken = unsignedLess;
      3'b111:  taken = ~unsignedLess;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core (shared ALU and memory).
// Optional MULTICYCLE_PERF_EN adds CycleCount/InstRet performance counters.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        Zero,
  input  logic        signedLess,
  input  logic        unsignedLess,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic        Illegal
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstRet
`endif
);

  state_t state, next_state;
  logic   taken;

  branch_resolve u_branch_resolve (
    .funct3       (funct3),
    .Zero         (Zero),
    .signedLess   (signedLess),
    .unsignedLess (unsignedLess),
    .taken        (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (MemReady) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXECR;
          OP_IMM:            next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          OP_LUI:            next_state = LUI;
          OP_AUIPC:          next_state = AUIPC;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (MemReady) next_state = MEMWB;
      MEMWRITE: if (MemReady) next_state = FETCH;
      EXECR, EXECI, LUI, AUIPC: next_state = ALUWB;
      JAL, JALR: next_state = JALLINK;
      MEMWB, ALUWB, BRANCH, JALLINK: next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // ImmSrc follows op in every state that feeds ImmExt to the ALU.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    Illegal   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          MemReq = 1'b1;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
          end
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = imm_src_for(op);
          Illegal = ~is_legal(op);
        end
        MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = imm_src_for(op);
        end
        MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        MEMWB: begin
          ResultSrc = RES_RDATA;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
        end
        EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
          ImmSrc  = imm_src_for(op);
        end
        LUI: begin
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = imm_src_for(op);
        end
        AUIPC: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = imm_src_for(op);
        end
        ALUWB:   RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_SUB;
          PCWrite = taken;
        end
        JAL:     PCWrite = 1'b1;
        JALR: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALURESULT;
          PCWrite   = 1'b1;
          ImmSrc    = imm_src_for(op);
        end
        JALLINK: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          RegWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  // DECODE only returns to FETCH on an illegal opcode, which does not retire.
  logic retire;
  assign retire = (state != FETCH) && (state != DECODE) && (next_state == FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      CycleCount <= 32'd0;
      InstRet    <= 32'd0;
    end else begin
      CycleCount <= CycleCount + 32'd1;
      if (retire) InstRet <= InstRet + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing FSM for the multicycle RV32I core: a single ALU and a unified instruction/data memory are shared across the fetch, decode, execute, memory and writeback steps of each instruction. The block drives the Moore-style enables and mux selects for PC, IR, the ALU operand muxes, the memory port and the register file. It stalls on a memory-ready handshake and resolves all six conditional branches from ALU flags. It replaces the single-cycle ControlUnit when the core is built multicycle.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode from instruction register
- funct3  in  3  from instruction register
- Zero, signedLess, unsignedLess  in  1 each  ALU flags
- MemReady  in  1  memory completes access this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  store (only with MemReq)
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- IRWrite  out  1  latch instruction and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 reg, 11 zero
- ALUSrcB  out  2  00 rs2 reg, 01 ImmExt, 10 const 4
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct decode
- ResultSrc  out  2  00 ALUOut, 01 read-data reg, 10 ALUResult
- ImmSrc  out  3  Extend format select, same encoding as Extend
- Illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALLINK, LUI, AUIPC.
- FETCH: MemReq=1, AdrSrc=0. While MemReady=0, hold with no other enables. When MemReady=1: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut = branch/JAL target. ImmSrc is taken from op.
  - Dispatch: load/store → MEMADR; OP → EXECR; OP-IMM → EXECI; BRANCH → BRANCH; JAL → JAL; JALR → JALR; LUI → LUI; AUIPC → AUIPC.
  - Any other op: Illegal=1 and go to FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Hold until MemReady, then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; go to ALUWB.
- EXECI: same as EXECR but ALUSrcB=01; go to ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; go to ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00; go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=taken. Go to FETCH.
  - taken: beq Zero; bne !Zero; blt signedLess; bge !signedLess; bltu unsignedLess; bgeu !unsignedLess.
  - funct3 010/011 → not taken.
- JAL: ResultSrc=00, PCWrite=1; go to JALLINK.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1; go to JALLINK.
- JALLINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1; go to FETCH.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are decoded from the state register only, except two: the MemReady-qualified IRWrite/PCWrite in FETCH, and the flag-qualified PCWrite in BRANCH.
- Reset: state ← FETCH next edge. While rst=1, all outputs are forced to 0, and any pending MemReq is dropped mid-access.
- MemReady=1 in the entry cycle of a memory state completes that state in one cycle.
- Latency with zero wait states:
  - R/I/LUI/AUIPC: 4 cycles
  - branch: 3 cycles
  - JAL/JALR: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
- Each wait cycle adds one cycle.
- op/funct3 must be stable from DECODE to instruction end (the IR holds them).
- Flags must be valid combinationally during BRANCH.

## Configuration
- MULTICYCLE_PERF_EN defined: adds two outputs, CycleCount (32) and InstRet (32). Both reset to 0.
  - CycleCount increments every cycle rst=0.
  - InstRet increments on every transition into FETCH from a non-FETCH state, except the Illegal path.
  - Both wrap at 2^32−1 → 0.
- Undefined: the ports and counters do not exist.

## Structure
- Package multicycle_pkg holds:
  - state_t enum
  - opcode localparams (0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111)
  - ALUSrcA/ALUSrcB/ResultSrc/ALUOp encodings
  - ImmSrc codes shared with Extend
- Sub-module branch_resolve: combinational funct3 + flags → taken.

## Test plan
- Reset: rst=1 for 2 cycles → all outputs 0. Release → MemReq=1, AdrSrc=0 on first cycle.
- add (op 0110011), MemReady tied 1 → FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in cycle 4. InstRet=1 (PERF_EN).
- lw, MemReady low for 3 cycles of MEMREAD → MEMREAD held 4 cycles, MemReq=1 throughout. MEMWB at cycle 8 with ResultSrc=01.
- bne (funct3 001): Zero=1 → PCWrite=0 in BRANCH; Zero=0 → PCWrite=1. bgeu with unsignedLess=0 → PCWrite=1.
- jalr → JALR: PCWrite=1, ResultSrc=10. Then JALLINK: RegWrite=1, ALUSrcA=01, ALUSrcB=10.
- op=0000000 → Illegal=1 in DECODE, then FETCH. No RegWrite/MemWrite/PCWrite after IRWrite; InstRet unchanged.
